// File: rtl/sprite_pkg.sv
// sprite_pkg: constants and types shared by the sprite datapath.
//   SPRITE_W / SPRITE_H : sprite bitmap geometry in pixels
//   player_state_t      : player animation state encoding
//   COLOR_*             : fixed RRRGGGBB colours used by the pixel mux
//   writer_state_t      : sprite_line_writer FSM state type and codes
package sprite_pkg;

  localparam int unsigned SPRITE_W = 150;
  localparam int unsigned SPRITE_H = 157;

  typedef enum logic [2:0] {
    IDLE         = 3'd0,
    MOVE_FWD     = 3'd1,
    MOVE_BACK    = 3'd2,
    ATTACK_START = 3'd3,
    ATTACK_END   = 3'd4,
    ATTACK_PULL  = 3'd5
  } player_state_t;

  localparam logic [7:0] COLOR_BACKGROUND = 8'b00100101;
  localparam logic [7:0] COLOR_HURTBOX    = 8'b00111110;

  typedef logic [1:0] writer_state_t;

  localparam writer_state_t WS_IDLE  = 2'd0;
  localparam writer_state_t WS_FETCH = 2'd1;
  localparam writer_state_t WS_DRAIN = 2'd2;
  localparam writer_state_t WS_SWAP  = 2'd3;

endpackage

// File: rtl/lat_pipe.sv
// lat_pipe: DEPTH-stage valid + data shift register. Used to align the
// column index of each ROM read with the data the ROM returns.
//   clk, rst     : clock, asynchronous active-low reset
//   in_valid     : entry valid at stage 0
//   in_data      : W-bit payload at stage 0
//   out_valid    : valid after DEPTH cycles
//   out_data     : payload after DEPTH cycles
module lat_pipe #(
  parameter int unsigned DEPTH = 1,
  parameter int unsigned W     = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  output logic [W-1:0] out_data
);

  logic [DEPTH-1:0] vld;
  logic [W-1:0]     dat [DEPTH];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        dat[i] <= '0;
      end
    end else begin
      vld[0] <= in_valid;
      dat[0] <= in_data;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        vld[i] <= vld[i-1];
        dat[i] <= dat[i-1];
      end
    end
  end

  assign out_valid = vld[DEPTH-1];
  assign out_data  = dat[DEPTH-1];

endmodule

// File: rtl/sprite_line_writer.sv
// sprite_line_writer: fetches one sprite row from the sprite ROM during
// hblank and writes it into the bank lb_bank of a double-buffered line
// buffer; the pixel mux reads bank ~lb_bank.
// Optional feature macro: SPRITE_LINE_WRITER_MIRROR_EN (adds 'flip' input,
// mirrors the line-buffer column order when flip=1).
// Ports:
//   clk, rst            : clock, asynchronous active-low reset
//   line_start          : hblank pulse, requests the row for next_y
//   next_y, posy        : target scanline and sprite top, sampled on line_start
//   flip                : (MIRROR_EN only) mirror horizontally, sampled on line_start
//   rom_rd, rom_addr    : ROM read strobe and address
//   rom_data            : RRRGGGBB pixel, ROM_LAT cycles after rom_rd
//   rom_visible         : opacity flag alongside rom_data
//   lb_we, lb_waddr     : line-buffer write enable and column
//   lb_wdata            : {visible, colour}
//   lb_bank             : bank being written
//   row_valid           : reader's bank holds a sprite row
//   busy, done          : not idle / one-cycle completion pulse
//   overrun             : sticky, line_start arrived while busy
module sprite_line_writer #(
  parameter int unsigned SPRITE_W = sprite_pkg::SPRITE_W,
  parameter int unsigned SPRITE_H = sprite_pkg::SPRITE_H,
  parameter int unsigned ROM_LAT  = 1,
  parameter int unsigned ADDR_W   = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              line_start,
  input  logic [9:0]        next_y,
  input  logic [9:0]        posy,
`ifdef SPRITE_LINE_WRITER_MIRROR_EN
  input  logic              flip,
`endif
  output logic              rom_rd,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [7:0]        rom_data,
  input  logic              rom_visible,
  output logic              lb_we,
  output logic [7:0]        lb_waddr,
  output logic [8:0]        lb_wdata,
  output logic              lb_bank,
  output logic              row_valid,
  output logic              busy,
  output logic              done,
  output logic              overrun
);

  import sprite_pkg::*;

  writer_state_t     state;
  logic [ADDR_W-1:0] base;
  logic [7:0]        col;
  logic [2:0]        drain_cnt;
  logic              pend_valid;

  logic [9:0]        row;
  logic              row_hit;
  logic              last_col;

  logic [7:0]        pipe_in_col;
  logic              pipe_out_valid;
  logic [7:0]        pipe_out_col;

  // Unsigned wrap makes a sprite below the line look like a huge row, so a
  // single compare rejects both above and below cases.
  assign row      = next_y - posy;
  assign row_hit  = 32'(row) < SPRITE_H;
  assign last_col = (col == 8'(SPRITE_W - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= WS_IDLE;
      base       <= '0;
      col        <= '0;
      drain_cnt  <= '0;
      pend_valid <= 1'b0;
      lb_bank    <= 1'b0;
      row_valid  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      // Any request outside IDLE (including the SWAP/done cycle) is dropped.
      if (line_start && (state != WS_IDLE)) begin
        overrun <= 1'b1;
      end

      case (state)
        WS_IDLE: begin
          if (line_start) begin
            if (row_hit) begin
              state      <= WS_FETCH;
              base       <= ADDR_W'(32'(row) * SPRITE_W);
              col        <= '0;
              pend_valid <= 1'b1;
            end else begin
              state      <= WS_SWAP;
              pend_valid <= 1'b0;
            end
          end
        end

        WS_FETCH: begin
          if (last_col) begin
            state     <= WS_DRAIN;
            drain_cnt <= '0;
          end else begin
            col <= col + 8'd1;
          end
        end

        WS_DRAIN: begin
          if (drain_cnt == 3'(ROM_LAT - 1)) begin
            state <= WS_SWAP;
          end else begin
            drain_cnt <= drain_cnt + 3'd1;
          end
        end

        WS_SWAP: begin
          lb_bank   <= ~lb_bank;
          row_valid <= pend_valid;
          state     <= WS_IDLE;
        end

        default: state <= WS_IDLE;
      endcase
    end
  end

`ifdef SPRITE_LINE_WRITER_MIRROR_EN
  logic flip_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      flip_q <= 1'b0;
    end else if (line_start && (state == WS_IDLE)) begin
      flip_q <= flip;
    end
  end

  // Mirroring only remaps the write column; ROM reads stay in order.
  assign pipe_in_col = flip_q ? (8'(SPRITE_W - 1) - col) : col;
`else
  assign pipe_in_col = col;
`endif

  assign rom_rd   = (state == WS_FETCH);
  assign rom_addr = rom_rd ? (base + ADDR_W'(col)) : '0;
  assign busy     = (state != WS_IDLE);
  assign done     = (state == WS_SWAP);

  lat_pipe #(
    .DEPTH (ROM_LAT),
    .W     (8)
  ) u_lat_pipe (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (rom_rd),
    .in_data   (pipe_in_col),
    .out_valid (pipe_out_valid),
    .out_data  (pipe_out_col)
  );

  // The write happens in the same cycle the ROM presents the pixel.
  assign lb_we    = pipe_out_valid;
  assign lb_waddr = pipe_out_valid ? pipe_out_col : '0;
  assign lb_wdata = pipe_out_valid ? {rom_visible, rom_data} : '0;

endmodule

// File: doc/sprite_line_writer.md
Name: sprite_line_writer

Overview:
- Fills a double-buffered scanline buffer with one sprite row per video line. It fetches that row from a sprite ROM during blanking.
- It is the writer end of the sprite pixel path. The pixel-colour mux reads bank ~lb_bank at pixel rate while this block writes bank lb_bank.
- It replaces per-pixel ROM addressing with one burst fetch per line.

Parameters:
- SPRITE_W, 150, sprite width in pixels; also the number of line-buffer entries used.
- SPRITE_H, 157, sprite height in rows.
- ROM_LAT, 1, ROM read latency in clk cycles; legal values are 1 to 4.
- ADDR_W, 15, ROM address width; must satisfy SPRITE_W*SPRITE_H <= 2^ADDR_W.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; asynchronous, active-low.
- line_start  in  1  single-cycle pulse at hblank start; requests the row for next_y.
- next_y  in  10  scanline to prepare; sampled on line_start.
- posy  in  10  sprite top y; sampled on line_start.
- rom_rd  out  1  ROM read strobe.
- rom_addr  out  ADDR_W  ROM address.
- rom_data  in  8  RRRGGGBB pixel; valid ROM_LAT cycles after rom_rd.
- rom_visible  in  1  opacity flag; valid alongside rom_data.
- lb_we  out  1  line-buffer write enable.
- lb_waddr  out  8  line-buffer column.
- lb_wdata  out  9  {visible, colour}.
- lb_bank  out  1  bank currently being written; the reader uses ~lb_bank.
- row_valid  out  1  the reader's bank holds a sprite row; when 0 the reader treats the whole line as transparent.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when a line completes.
- overrun  out  1  sticky error flag.

Behaviour:
- Reset (rst=0, asynchronous): state IDLE. All of these are 0: rom_rd, rom_addr, lb_we, lb_waddr, lb_wdata, lb_bank, row_valid, busy, done, overrun.
- Row computation: row = next_y - posy, 10-bit unsigned. A sprite starting below the line wraps to a large value, so the single test row < SPRITE_H covers both sprite-above and sprite-below cases.
- FSM states: IDLE, FETCH, DRAIN, SWAP.
- IDLE to FETCH: on line_start with row < SPRITE_H. Latch base = row*SPRITE_W and set col = 0.
- IDLE to SWAP: on line_start with row >= SPRITE_H. Set pend_valid = 0; no ROM reads and no writes occur.
- FETCH: each cycle assert rom_rd with rom_addr = base + col, then increment col. After issuing col = SPRITE_W-1, go to DRAIN. Set pend_valid = 1.
- Write path:
  - col is carried through a ROM_LAT-deep valid/column shift pipe.
  - When the pipe output is valid: lb_we = 1, lb_waddr = piped col, lb_wdata = {rom_visible, rom_data}.
  - Writes are combinational from the pipe output, in the cycle the ROM data is valid.
- DRAIN: lasts exactly ROM_LAT cycles, until the pipe is empty, then go to SWAP.
- SWAP: lasts one cycle. done = 1 for that cycle. At the closing edge lb_bank toggles, row_valid <= pend_valid, and the state returns to IDLE.
- Timing, with line_start sampled at edge 0:
  - rom_rd is high in cycles 1..SPRITE_W.
  - Writes occur in cycles 1+ROM_LAT .. SPRITE_W+ROM_LAT.
  - done is high in cycle SPRITE_W+ROM_LAT+1.
  - For an off-sprite row, done is high in cycle 1.
- line_start while busy: ignored and the current fetch continues. overrun is set and stays set until reset.
- line_start coinciding with the done cycle: also counts as busy, so it is ignored and sets overrun.
- Reset mid-fetch: everything aborts immediately to the reset values. The partially written bank is never exposed because row_valid = 0.
- Widths: base+col never exceeds SPRITE_W*SPRITE_H-1. col is held in 8 bits.

Optional Feature:
- Macro: SPRITE_LINE_WRITER_MIRROR_EN.
- When defined:
  - Adds input port flip (1 bit), sampled on line_start.
  - If flip = 1, lb_waddr = SPRITE_W-1-col. The ROM address order is unchanged.
  - Used to render the player-2 sprite facing left.
- When undefined: the flip port is absent and lb_waddr = col.

Decomposition:
- Shared package sprite_pkg holds:
  - SPRITE_W and SPRITE_H constants.
  - The player state encoding: IDLE=0, MOVE_FWD=1, MOVE_BACK=2, ATTACK_START=3, ATTACK_END=4, ATTACK_PULL=5.
  - Colour constants: background 8'b00100101, hurtbox 8'b00111110.
  - The writer FSM state typedef.
- Sub-module lat_pipe, a parameterised ROM_LAT-deep valid+data shift register, is the natural split.

Test Plan:
- posy=100, next_y=110, ROM_LAT=1 → rom_addr runs 1500..1649 in cycles 1..150. 150 writes with lb_waddr 0..149. done is high in cycle 152, then lb_bank=1 and row_valid=1.
- posy=200, next_y=50 (row wraps to 874) → no rom_rd and no lb_we. done is high in cycle 1, then row_valid=0 and the bank toggles.
- Row 156 (last) accepted and row 157 rejected → for row 156 the final rom_addr is 23549.
- line_start again at cycle 40 of a fetch → overrun=1. The original line completes unchanged and done is high at cycle 152.
- rst low at cycle 60 of a fetch → all outputs 0 immediately. A new line_start after release behaves normally, and overrun stays cleared.
- ROM_LAT=3 with the MIRROR_EN macro defined and flip=1 → the first write lands at cycle 4 with lb_waddr=149, and done is high in cycle 154.
